// File: rtl/scalar_scoreboard_ctrl.sv
// Scoreboard controller for the ALU, LD_ST and BRANCH scalar units. It keeps the FU status and
// register result-status tables, gates dispatch and operand read, and arbitrates writeback.
module scalar_scoreboard_ctrl #(
  parameter int unsigned NUM_FU = 3,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned NREGS  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              disp_valid,
  input  logic [1:0]        disp_fu,
  input  logic              disp_rd_en,
  input  logic [REG_W-1:0]  disp_rd,
  input  logic [REG_W-1:0]  disp_rs1,
  input  logic [REG_W-1:0]  disp_rs2,
  output logic              disp_ready,
  output logic [NUM_FU-1:0] ex_start,
  input  logic [NUM_FU-1:0] fu_done,
  output logic [NUM_FU-1:0] wb_grant,
  output logic              wb_we,
  output logic [REG_W-1:0]  wb_rd,
  output logic [NUM_FU-1:0] busy
);

  typedef logic [1:0] fu_idx_t;

  // FU status table, one row per functional unit
  logic [NUM_FU-1:0] busy_q;
  logic [NUM_FU-1:0] started_q;
  logic [NUM_FU-1:0] rd_en_q;
  logic [NUM_FU-1:0] rdy1_q;
  logic [NUM_FU-1:0] rdy2_q;
  logic [REG_W-1:0]  r_q  [NUM_FU];
  logic [REG_W-1:0]  r1_q [NUM_FU];
  logic [REG_W-1:0]  r2_q [NUM_FU];
  fu_idx_t           t1_q [NUM_FU];
  fu_idx_t           t2_q [NUM_FU];

  // Register result status: pending bit plus producing FU
  logic [NREGS-1:0]  rstat_valid_q;
  fu_idx_t           rstat_fu_q [NREGS];

  // High for the cycle after reset so every output stays quiet one extra cycle
  logic              rst_q;

  logic              out_en;
  logic              fu_free;
  logic              waw_hazard;
  logic              issue;
  logic              src1_rdy;
  logic              src2_rdy;
  fu_idx_t           src1_fu;
  fu_idx_t           src2_fu;
  logic [NUM_FU-1:0] war_block;
  logic [NUM_FU-1:0] wb_elig;
  logic              gnt_any;
  fu_idx_t           gnt_idx;
  logic              gnt_rd_en;
  logic [REG_W-1:0]  gnt_rd;

  assign out_en = !(RST || rst_q);

  // Operand read, WAR-qualified writeback eligibility and fixed-priority grant
  always_comb begin
    ex_start  = '0;
    war_block = '0;
    wb_elig   = '0;
    for (int f = 0; f < int'(NUM_FU); f++) begin
      ex_start[f] = out_en && busy_q[f] && !started_q[f] && rdy1_q[f] && rdy2_q[f];
      for (int g = 0; g < int'(NUM_FU); g++) begin
        if (g != f && busy_q[g] && !started_q[g] &&
            ((r1_q[g] == r_q[f] && rdy1_q[g]) || (r2_q[g] == r_q[f] && rdy2_q[g]))) begin
          war_block[f] = 1'b1;
        end
      end
      wb_elig[f] = out_en && fu_done[f] && busy_q[f] && started_q[f] &&
                   !(rd_en_q[f] && war_block[f]);
    end

    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int f = int'(NUM_FU) - 1; f >= 0; f--) begin
      if (wb_elig[f]) begin
        gnt_any = 1'b1;
        gnt_idx = fu_idx_t'(f);
      end
    end

    wb_grant  = '0;
    gnt_rd_en = 1'b0;
    gnt_rd    = '0;
    for (int f = 0; f < int'(NUM_FU); f++) begin
      if (gnt_any && gnt_idx == fu_idx_t'(f)) begin
        wb_grant[f] = 1'b1;
        gnt_rd_en   = rd_en_q[f];
        gnt_rd      = r_q[f];
      end
    end
    wb_we = gnt_rd_en && (gnt_rd != '0);
    wb_rd = gnt_rd;
    busy  = out_en ? busy_q : '0;
  end

  // Dispatch acceptance and source readiness, including wakeup from this cycle's grant
  always_comb begin
    fu_free = 1'b0;
    for (int f = 0; f < int'(NUM_FU); f++) begin
      if (int'(disp_fu) == f) fu_free = !busy_q[f];
    end
    waw_hazard = disp_rd_en && (disp_rd != '0) && rstat_valid_q[disp_rd];
    disp_ready = out_en && fu_free && !waw_hazard;
    issue      = disp_valid && disp_ready;

    src1_fu  = rstat_fu_q[disp_rs1];
    src2_fu  = rstat_fu_q[disp_rs2];
    src1_rdy = (disp_rs1 == '0) || !rstat_valid_q[disp_rs1] || (gnt_any && src1_fu == gnt_idx);
    src2_rdy = (disp_rs2 == '0) || !rstat_valid_q[disp_rs2] || (gnt_any && src2_fu == gnt_idx);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rst_q         <= 1'b1;
      busy_q        <= '0;
      started_q     <= '0;
      rd_en_q       <= '0;
      rdy1_q        <= '0;
      rdy2_q        <= '0;
      rstat_valid_q <= '0;
      for (int f = 0; f < int'(NUM_FU); f++) begin
        r_q[f]  <= '0;
        r1_q[f] <= '0;
        r2_q[f] <= '0;
        t1_q[f] <= '0;
        t2_q[f] <= '0;
      end
      for (int i = 0; i < int'(NREGS); i++) begin
        rstat_fu_q[i] <= '0;
      end
    end else begin
      rst_q <= 1'b0;
      for (int f = 0; f < int'(NUM_FU); f++) begin
        if (wb_grant[f]) busy_q[f] <= 1'b0;
        if (ex_start[f]) started_q[f] <= 1'b1;
        if (gnt_any && !rdy1_q[f] && t1_q[f] == gnt_idx) rdy1_q[f] <= 1'b1;
        if (gnt_any && !rdy2_q[f] && t2_q[f] == gnt_idx) rdy2_q[f] <= 1'b1;
        // The issuing row is idle, so it never collides with the grant/start updates above
        if (issue && int'(disp_fu) == f) begin
          busy_q[f]    <= 1'b1;
          started_q[f] <= 1'b0;
          rd_en_q[f]   <= disp_rd_en;
          r_q[f]       <= disp_rd;
          r1_q[f]      <= disp_rs1;
          r2_q[f]      <= disp_rs2;
          t1_q[f]      <= src1_fu;
          t2_q[f]      <= src2_fu;
          rdy1_q[f]    <= src1_rdy;
          rdy2_q[f]    <= src2_rdy;
        end
      end

      // Only the owning FU may clear a pending entry
      if (gnt_any && gnt_rd_en && rstat_valid_q[gnt_rd] && rstat_fu_q[gnt_rd] == gnt_idx) begin
        rstat_valid_q[gnt_rd] <= 1'b0;
      end
      if (issue && disp_rd_en && disp_rd != '0) begin
        rstat_valid_q[disp_rd] <= 1'b1;
        rstat_fu_q[disp_rd]    <= disp_fu;
      end
    end
  end

endmodule

// File: tb/tb_scalar_scoreboard_ctrl.sv
// Directed bench for scalar_scoreboard_ctrl: structural, RAW, WAW, WAR, priority and reset cases,
// with expected writebacks queued at dispatch and matched when the grant appears.
module tb_scalar_scoreboard_ctrl;

  logic       CLK;
  logic       RST;
  logic       disp_valid;
  logic [1:0] disp_fu;
  logic       disp_rd_en;
  logic [4:0] disp_rd;
  logic [4:0] disp_rs1;
  logic [4:0] disp_rs2;
  logic       disp_ready;
  logic [2:0] ex_start;
  logic [2:0] fu_done;
  logic [2:0] wb_grant;
  logic       wb_we;
  logic [4:0] wb_rd;
  logic [2:0] busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [1:0] fu;
    logic       we;
    logic [4:0] rd;
  } wb_t;

  wb_t sb_q[$];

  scalar_scoreboard_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .disp_valid (disp_valid),
    .disp_fu    (disp_fu),
    .disp_rd_en (disp_rd_en),
    .disp_rd    (disp_rd),
    .disp_rs1   (disp_rs1),
    .disp_rs2   (disp_rs2),
    .disp_ready (disp_ready),
    .ex_start   (ex_start),
    .fu_done    (fu_done),
    .wb_grant   (wb_grant),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of run, expected $finish before 100000");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drv(input logic v, input logic [1:0] fu, input logic en, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2);
    disp_valid = v;
    disp_fu    = fu;
    disp_rd_en = en;
    disp_rd    = rd;
    disp_rs1   = rs1;
    disp_rs2   = rs2;
  endtask

  task automatic idle();
    drv(1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic push_wb(input logic [1:0] fu, input logic we, input logic [4:0] rd);
    sb_q.push_back({fu, we, rd});
  endtask

  // Pops the oldest queued writeback for the FU the bench expects to win this cycle
  task automatic expect_wb(input string tag, input logic [1:0] fu);
    int  idx;
    wb_t e;
    idx = -1;
    for (int i = 0; i < sb_q.size(); i++) begin
      if (idx < 0 && sb_q[i].fu == fu) idx = i;
    end
    if (idx < 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: observed grant %0b with no queued entry for fu %0d", tag, wb_grant, fu);
      return;
    end
    e = sb_q[idx];
    sb_q.delete(idx);
    chk({tag, "_grant"}, 32'(wb_grant), 32'(1) << fu);
    chk({tag, "_we"}, 32'(wb_we), 32'(e.we));
    chk({tag, "_rd"}, 32'(wb_rd), 32'(e.rd));
  endtask

  initial begin
    RST     = 1'b1;
    fu_done = 3'b000;
    idle();

    // Reset: outputs quiet while RST high and for one cycle after
    tick();
    drv(1'b1, 2'd0, 1'b1, 5'd5, 5'd1, 5'd2);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(wb_grant), 0);
    chk("rst_ready", 32'(disp_ready), 0);
    tick();
    RST = 1'b0;
    #1;
    chk("post_rst_ready", 32'(disp_ready), 0);
    chk("post_rst_ex", 32'(ex_start), 0);
    tick();

    // Structural hazard on ALU
    #1;
    chk("idle_ready_alu", 32'(disp_ready), 1);
    push_wb(2'd0, 1'b1, 5'd5);
    tick();
    drv(1'b1, 2'd0, 1'b1, 5'd8, 5'd1, 5'd1);
    #1;
    chk("struct_busy", 32'(busy), 32'b001);
    chk("struct_ex", 32'(ex_start), 32'b001);
    chk("struct_ready", 32'(disp_ready), 0);
    tick();
    fu_done = 3'b001;
    #1;
    chk("struct_ex_once", 32'(ex_start), 0);
    expect_wb("alu_x5", 2'd0);
    chk("struct_ready_gnt", 32'(disp_ready), 0);
    tick();
    fu_done = 3'b000;
    #1;
    chk("struct_busy_clr", 32'(busy), 0);
    chk("struct_ready_after", 32'(disp_ready), 1);
    push_wb(2'd0, 1'b1, 5'd8);
    tick();
    idle();
    fu_done = 3'b001;
    #1;
    chk("alu_x8_ex", 32'(ex_start), 32'b001);
    chk("done_not_started", 32'(wb_grant), 0);
    tick();
    #1;
    expect_wb("alu_x8", 2'd0);
    tick();

    // RAW without bypass
    fu_done = 3'b000;
    drv(1'b1, 2'd0, 1'b1, 5'd5, 5'd1, 5'd2);
    #1;
    push_wb(2'd0, 1'b1, 5'd5);
    tick();
    drv(1'b1, 2'd1, 1'b1, 5'd6, 5'd5, 5'd0);
    #1;
    chk("raw_alu_ex", 32'(ex_start), 32'b001);
    chk("raw_ready", 32'(disp_ready), 1);
    push_wb(2'd1, 1'b1, 5'd6);
    tick();
    idle();
    fu_done = 3'b001;
    #1;
    chk("raw_busy", 32'(busy), 32'b011);
    chk("raw_hold", 32'(ex_start), 0);
    expect_wb("raw_alu_x5", 2'd0);
    tick();
    fu_done = 3'b000;
    #1;
    chk("raw_wake", 32'(ex_start), 32'b010);
    tick();
    fu_done = 3'b010;
    #1;
    expect_wb("raw_ldst_x6", 2'd1);
    tick();

    // RAW with same-cycle grant bypass
    fu_done = 3'b000;
    drv(1'b1, 2'd0, 1'b1, 5'd5, 5'd1, 5'd2);
    #1;
    push_wb(2'd0, 1'b1, 5'd5);
    tick();
    idle();
    #1;
    chk("byp_alu_ex", 32'(ex_start), 32'b001);
    tick();
    fu_done = 3'b001;
    drv(1'b1, 2'd1, 1'b1, 5'd6, 5'd5, 5'd0);
    #1;
    chk("byp_ready", 32'(disp_ready), 1);
    chk("byp_ex_none", 32'(ex_start), 0);
    expect_wb("byp_alu_x5", 2'd0);
    push_wb(2'd1, 1'b1, 5'd6);
    tick();
    idle();
    fu_done = 3'b000;
    #1;
    chk("byp_wake", 32'(ex_start), 32'b010);
    chk("byp_busy", 32'(busy), 32'b010);
    tick();
    fu_done = 3'b010;
    #1;
    expect_wb("byp_ldst_x6", 2'd1);
    tick();

    // WAW on x7
    fu_done = 3'b000;
    drv(1'b1, 2'd0, 1'b1, 5'd7, 5'd1, 5'd2);
    #1;
    push_wb(2'd0, 1'b1, 5'd7);
    tick();
    drv(1'b1, 2'd2, 1'b1, 5'd7, 5'd0, 5'd0);
    #1;
    chk("waw_alu_ex", 32'(ex_start), 32'b001);
    chk("waw_block", 32'(disp_ready), 0);
    tick();
    fu_done = 3'b001;
    #1;
    expect_wb("waw_alu_x7", 2'd0);
    chk("waw_block_gnt", 32'(disp_ready), 0);
    tick();
    fu_done = 3'b000;
    #1;
    chk("waw_release", 32'(disp_ready), 1);
    push_wb(2'd2, 1'b1, 5'd7);
    tick();
    idle();
    #1;
    chk("waw_br_ex", 32'(ex_start), 32'b100);
    tick();
    fu_done = 3'b100;
    #1;
    expect_wb("waw_br_x7", 2'd2);
    tick();

    // WAR: LD_ST reads x3 while waiting on x4; ALU writing x3 must hold off
    fu_done = 3'b000;
    drv(1'b1, 2'd2, 1'b1, 5'd4, 5'd0, 5'd0);
    #1;
    push_wb(2'd2, 1'b1, 5'd4);
    tick();
    drv(1'b1, 2'd1, 1'b1, 5'd9, 5'd3, 5'd4);
    #1;
    chk("war_br_ex", 32'(ex_start), 32'b100);
    chk("war_ldst_ready", 32'(disp_ready), 1);
    push_wb(2'd1, 1'b1, 5'd9);
    tick();
    drv(1'b1, 2'd0, 1'b1, 5'd3, 5'd1, 5'd2);
    #1;
    chk("war_alu_ready", 32'(disp_ready), 1);
    chk("war_ex_none", 32'(ex_start), 0);
    push_wb(2'd0, 1'b1, 5'd3);
    tick();
    idle();
    #1;
    chk("war_busy", 32'(busy), 32'b111);
    chk("war_alu_ex", 32'(ex_start), 32'b001);
    tick();
    fu_done = 3'b001;
    #1;
    chk("war_block", 32'(wb_grant), 0);
    tick();
    fu_done = 3'b101;
    #1;
    expect_wb("war_br_x4", 2'd2);
    chk("war_ldst_wait", 32'(ex_start), 0);
    tick();
    fu_done = 3'b001;
    #1;
    chk("war_ldst_ex", 32'(ex_start), 32'b010);
    chk("war_hold", 32'(wb_grant), 0);
    tick();
    #1;
    expect_wb("war_alu_x3", 2'd0);
    tick();
    fu_done = 3'b010;
    #1;
    expect_wb("war_ldst_x9", 2'd1);
    tick();

    // Priority with ALU writing x0
    fu_done = 3'b000;
    drv(1'b1, 2'd0, 1'b1, 5'd0, 5'd1, 5'd2);
    #1;
    push_wb(2'd0, 1'b0, 5'd0);
    tick();
    drv(1'b1, 2'd1, 1'b1, 5'd10, 5'd0, 5'd0);
    #1;
    push_wb(2'd1, 1'b1, 5'd10);
    tick();
    drv(1'b1, 2'd2, 1'b1, 5'd11, 5'd0, 5'd0);
    #1;
    push_wb(2'd2, 1'b1, 5'd11);
    tick();
    idle();
    #1;
    chk("prio_busy", 32'(busy), 32'b111);
    tick();
    fu_done = 3'b111;
    #1;
    expect_wb("prio_alu", 2'd0);
    tick();
    #1;
    expect_wb("prio_ldst", 2'd1);
    tick();
    #1;
    expect_wb("prio_br", 2'd2);
    tick();

    // Same setup, reset after the first grant aborts the rest
    fu_done = 3'b000;
    #1;
    chk("prio_idle", 32'(busy), 0);
    drv(1'b1, 2'd0, 1'b1, 5'd0, 5'd1, 5'd2);
    push_wb(2'd0, 1'b0, 5'd0);
    tick();
    drv(1'b1, 2'd1, 1'b1, 5'd10, 5'd0, 5'd0);
    tick();
    drv(1'b1, 2'd2, 1'b1, 5'd11, 5'd0, 5'd0);
    tick();
    idle();
    tick();
    fu_done = 3'b111;
    #1;
    expect_wb("rst_seq_alu", 2'd0);
    tick();
    RST = 1'b1;
    #1;
    chk("rst_mid_grant", 32'(wb_grant), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    tick();
    RST = 1'b0;
    #1;
    chk("rst_after_grant", 32'(wb_grant), 0);
    chk("rst_after_busy", 32'(busy), 0);
    chk("rst_after_ready", 32'(disp_ready), 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_no_grant", 32'(wb_grant), 0);
      chk("rst_no_busy", 32'(busy), 0);
      chk("rst_ready_back", 32'(disp_ready), 1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
